// File: rtl/alu_issue_unit.sv
// alu_issue_unit: 8-entry regfile issue/writeback stage in front of a registered 3-bit-select ALU.
// Optional feature: define ALU_ISSUE_ZFLAG_EN to add a zero_flag output captured at writeback.
module alu_issue_unit #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3+3*ADDR_W-1:0] instr,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic [DATA_W-1:0]     alu_in1,
  output logic [DATA_W-1:0]     alu_in2,
  output logic [2:0]            alu_select,
  input  logic [DATA_W-1:0]     alu_result,
`ifdef ALU_ISSUE_ZFLAG_EN
  output logic                  zero_flag,
`endif
  output logic                  done
);
  localparam int NREG  = 2**ADDR_W;
  localparam int CNT_W = $clog2(ALU_LAT+1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]           rd_q, rd_d;
  logic [DATA_W-1:0]           in1_q, in1_d, in2_q, in2_d;
  logic [2:0]                  sel_q, sel_d;
  logic                        done_q, done_d;
  logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [2:0]                  op;
  logic [ADDR_W-1:0]           rd, rs1, rs2;
  logic                        wb;

  assign {op, rd, rs1, rs2} = instr;
  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign rd_data     = regs_q[rd_addr];
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign alu_select  = sel_q;
  assign done        = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    wb      = 1'b0;
    case (state_q)
      S_IDLE: if (instr_valid && instr_ready) begin
        // operands come from pre-edge contents; a same-edge external write is not forwarded
        rd_d    = rd;
        in1_d   = regs_q[rs1];
        in2_d   = regs_q[rs2];
        sel_d   = op;
        cnt_d   = CNT_W'(ALU_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_WB;
      end
      S_WB: begin
        wb      = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // writeback is applied last so it beats a same-edge external write to the same index
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
    if (wb)    regs_d[rd_q]    = alu_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end

`ifdef ALU_ISSUE_ZFLAG_EN
  logic zf_q, zf_d;

  always_comb zf_d = wb ? (alu_result == '0) : zf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) zf_q <= 1'b0;
    else     zf_q <= zf_d;
  end

  assign zero_flag = zf_q;
`endif
endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: two lanes (ALU_LAT 1 and 3), each with its own ALU model,
// directed scenarios then randomized instructions checked against a plain regfile model.
module tb_alu_issue_unit;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_IDEN = 3'd2, OP_LS = 3'd3,
                         OP_RS  = 3'd4, OP_AND = 3'd5, OP_NOT  = 3'd6, OP_OR = 3'd7;

  typedef struct packed {
    logic [2:0] rd;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [2:0] sel;
    logic [7:0] res;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests   = 0;
  int fails   = 0;
  int fin_cnt = 0;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_IDEN: return a;
      OP_LS:   return a << 1;
      OP_RS:   return a >> 1;
      OP_AND:  return a & b;
      OP_NOT:  return ~a;
      default: return a | b;
    endcase
  endfunction

  task automatic check(input int lane, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL lane%0d %s: got 0x%0h, expected 0x%0h", lane, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rst, instr_valid, instr_ready, wr_en, done;
    logic [11:0] instr;
    logic [2:0]  wr_addr, rd_addr, stim_addr, mon_addr, alu_select;
    logic [7:0]  wr_data, rd_data, alu_in1, alu_in2, alu_result;
`ifdef ALU_ISSUE_ZFLAG_EN
    logic        zero_flag;
`endif
    logic [7:0]  pipe [LAT];
    logic [7:0]  mregs [8];
    exp_t        sb [$];

    alu_issue_unit #(.DATA_W(8), .ADDR_W(3), .ALU_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_select(alu_select), .alu_result(alu_result),
`ifdef ALU_ISSUE_ZFLAG_EN
      .zero_flag(zero_flag),
`endif
      .done(done)
    );

    // external ALU: result appears LAT edges after operands
    always @(posedge clk) begin
      pipe[0] <= alu_f(alu_select, alu_in1, alu_in2);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_result = pipe[LAT-1];
    assign rd_addr    = done ? mon_addr : stim_addr;

    // monitor: pops the scoreboard on every done, checks held operands while busy
    initial begin
      exp_t e;
      mon_addr = '0;
      forever begin
        @(negedge clk);
        if (rst) continue;
        if (done) begin
          check(g, "pending_on_done", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            mon_addr = e.rd;
            #1;
            check(g, "wb_value", 32'(rd_data), 32'(e.res));
`ifdef ALU_ISSUE_ZFLAG_EN
            check(g, "zero_flag", 32'(zero_flag), 32'(e.res == 8'h00));
`endif
            mregs[e.rd] = e.res;
          end
        end else if (!instr_ready && sb.size() != 0) begin
          e = sb[0];
          check(g, "alu_ops_held", 32'({alu_in1, alu_in2, alu_select}), 32'({e.in1, e.in2, e.sel}));
        end
      end
    end

    task automatic cyc();
      @(negedge clk);
      #2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
      mregs[a] = d;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
      exp_t e;
      int n = 0;
      instr = {op, rd, rs1, rs2};
      instr_valid = 1'b1;
      while (!instr_ready && n < 100) begin cyc(); n++; end
      if (!instr_ready) check(g, "accept_timeout", 32'(instr_ready), 1);
      else begin
        e.rd = rd; e.in1 = mregs[rs1]; e.in2 = mregs[rs2]; e.sel = op;
        e.res = alu_f(op, e.in1, e.in2);
        sb.push_back(e);
      end
      cyc();
      instr_valid = 1'b0;
      instr = 12'($urandom);
    endtask

    task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || done || !instr_ready) && n < 100) begin cyc(); n++; end
      if (n >= 100) check(g, "idle_timeout", 32'(sb.size()), 0);
    endtask

    task automatic dump(input string nm);
      for (int i = 0; i < 8; i++) begin
        stim_addr = 3'(i);
        #1;
        check(g, nm, 32'(rd_data), 32'(mregs[i]));
      end
    endtask

    initial begin
      int busy;
      rst = 1'b1; instr_valid = 1'b0; instr = '0; wr_en = 1'b0;
      wr_addr = '0; wr_data = '0; stim_addr = '0;
      for (int i = 0; i < 8; i++) mregs[i] = '0;
      cyc();
      check(g, "ready_in_rst", 32'(instr_ready), 0);
      rst = 1'b0;
      cyc();
      check(g, "reset_outputs", 32'({instr_ready, done, alu_in1, alu_in2, alu_select}), 32'({1'b1, 20'd0}));
`ifdef ALU_ISSUE_ZFLAG_EN
      check(g, "reset_zflag", 32'(zero_flag), 0);
`endif
      dump("reset_regs");

      // ADD 0xCC+0x33, busy window and done alignment with ready
      wr(3'd1, 8'hCC); wr(3'd2, 8'h33);
      issue(OP_ADD, 3'd3, 3'd1, 3'd2);
      busy = 0;
      while (!instr_ready && busy < 20) begin busy++; cyc(); end
      check(g, "busy_cycles", 32'(busy), 32'(LAT + 1));
      check(g, "done_with_ready", 32'(done), 1);

      // SUB then dependent LS issued back to back (valid held while busy)
      wait_idle();
      wr(3'd1, 8'hAA); wr(3'd2, 8'h55);
      issue(OP_SUB, 3'd4, 3'd1, 3'd2);
      issue(OP_LS, 3'd5, 3'd4, 3'd0);

      // NOT to zero, then OR back to 0xFF
      wait_idle();
      wr(3'd6, 8'hFF);
      issue(OP_NOT, 3'd7, 3'd6, 3'd0);
      issue(OP_OR, 3'd0, 3'd4, 3'd5);

      // wrap-around ADD with an external write colliding on the WB edge
      wait_idle();
      wr(3'd1, 8'hFF); wr(3'd2, 8'h01);
      issue(OP_ADD, 3'd3, 3'd1, 3'd2);
      repeat (LAT) cyc();
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A;
      cyc();
      wr_en = 1'b0;
      wait_idle();
      dump("collision_regs");

      // reset while waiting on the ALU
      issue(OP_ADD, 3'd2, 3'd1, 3'd1);
      rst = 1'b1;
      cyc();
      sb.delete();
      for (int i = 0; i < 8; i++) mregs[i] = '0;
      check(g, "ready_in_mid_rst", 32'(instr_ready), 0);
      rst = 1'b0;
      cyc();
      check(g, "rst_outputs", 32'({instr_ready, done, alu_in1, alu_in2, alu_select}), 32'({1'b1, 20'd0}));
      repeat (LAT + 3) cyc();
      check(g, "no_done_after_rst", 32'(done), 0);
      dump("rst_regs");
      wr(3'd1, 8'h12); wr(3'd2, 8'h34);
      issue(OP_ADD, 3'd0, 3'd1, 3'd2);
      wait_idle();

      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(3) == 0) begin
          wait_idle();
          wr(3'($urandom_range(7)), 8'($urandom));
        end
        issue(3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)));
        if ($urandom_range(2) == 0) repeat ($urandom_range(3)) cyc();
      end
      wait_idle();
      dump("final_regs");
      fin_cnt++;
    end
  end

  initial begin
    int n = 0;
    while (fin_cnt < 2 && n < 60000) begin @(negedge clk); n++; end
    check(-1, "lanes_finished", 32'(fin_cnt), 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
